rom_ctrl: RTL and testbench
===========================

ROM_CTRL -- requirements
Module: rom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_load_start  input  1  a one-cycle pulse that starts a load session.
REQ-006 SHALL have port i_load_len  input  ADDR_WIDTH+1  word count, sampled with i_load_start.
REQ-007 SHALL have port i_s_data / i_s_valid / o_s_ready  in/in/out  DATA_WIDTH/1/1  load stream.
REQ-008 SHALL have port i_rd_addr / i_rd_valid / o_rd_ready  in/in/out  ADDR_WIDTH/1/1  read request.
REQ-009 SHALL have port o_rd_data / o_rd_err / o_rd_valid / i_rd_rsp_ready  out/out/out/in  DATA_WIDTH/1/1/1  read response.
REQ-010 SHALL have port o_rom_wr_data / o_rom_we / o_rom_addr  out/out/out  DATA_WIDTH/1/ADDR_WIDTH  drive the ROM's write data, write enable and address ports.
REQ-011 SHALL have port i_rom_rd_data  input  DATA_WIDTH  the ROM's read output.
REQ-012 SHALL have ports o_load_done (1-cycle pulse), o_load_err (1-cycle pulse) and o_loaded (level), all outputs, width 1.

Function
REQ-013 SHALL model the downstream ROM as follows: the ROM registers we, addr and wr_data at edge E. The write commits at edge E+1. The read data for the address registered at E is valid after E.
REQ-014 SHALL drive all o_rom_* outputs from flops.
REQ-015 SHALL implement the states IDLE, LOAD, FLUSH and READY.
REQ-016 SHALL, on an i_load_start pulse in IDLE or READY with 1 <= i_load_len <= 2^ADDR_WIDTH, latch the length, clear the word counter, clear o_loaded and enter LOAD.
REQ-017 SHALL, on i_load_start with i_load_len = 0 or i_load_len > 2^ADDR_WIDTH, pulse o_load_err and leave the state unchanged.
REQ-018 SHALL ignore i_load_start in LOAD and FLUSH.
REQ-019 SHALL, in LOAD, assert o_s_ready. Each beat with i_s_valid and o_s_ready sets, in the next cycle, o_rom_we=1, o_rom_addr=counter and o_rom_wr_data=i_s_data, then increments the counter.
REQ-020 SHALL hold o_rom_we at 0 in every cycle without a beat.
REQ-021 SHALL, once the final beat (counter = len-1) is accepted, deassert o_s_ready and enter FLUSH.
REQ-022 SHALL stay in FLUSH for 2 cycles so the last write commits, then enter READY, pulse o_load_done and set o_loaded.
REQ-023 SHALL, in READY, hold o_rd_ready=1 only when no read is in flight and the response register is empty.
REQ-024 SHALL, on a read accepted at edge N, set o_rom_addr=i_rd_addr after N and capture i_rom_rd_data into o_rd_data after N+2, asserting o_rd_valid then; the fixed latency is 2 cycles and at most one read is outstanding.
REQ-025 SHALL, for a read address >= the latched len, return o_rd_data=0 with o_rd_err=1 at the same latency.
REQ-026 SHALL hold o_rd_valid, o_rd_data and o_rd_err stable until i_rd_rsp_ready is high, and clear o_rd_valid in the cycle after the handshake.
REQ-027 SHALL allow a new request to be accepted in the cycle after the response handshake.
REQ-028 SHALL, when a load starts in READY while a read is in flight, complete that read before LOAD begins accepting beats.

Reset
REQ-029 SHALL, on rst, enter IDLE and set o_s_ready, o_rd_ready, o_rd_valid, o_rd_err, o_rom_we, o_load_done, o_load_err and o_loaded to 0, and o_rom_addr, o_rom_wr_data, o_rd_data, the counter and the latched len to 0.
REQ-030 SHALL abort any load or read in progress when rst is asserted mid-operation, discarding any partial response.

Structure
REQ-031 SHALL place the state enum type and the ROM latency constant (2) in a package named rom_pkg.
REQ-032 SHALL include in the bench one instance of rom (sub-module name rom) connected to the o_rom_* / i_rom_rd_data ports, so that the controller and ROM are checked together.

Verification
REQ-033 SHALL cover: load len=4 with data 0xA0..0xA3 and no stalls -> o_rom_we on 4 consecutive cycles at addresses 0..3, o_load_done 3 cycles after the last beat, then o_loaded=1.
REQ-034 SHALL cover: after that load, read addresses 2 then 3 -> o_rd_data 0xA2 then 0xA3 with o_rd_err=0, each 2 cycles after acceptance.
REQ-035 SHALL cover: read address 5 after a len=4 load -> o_rd_data=0, o_rd_err=1.
REQ-036 SHALL cover: i_rd_rsp_ready held low for 5 cycles -> response held stable and o_rd_ready=0 throughout.
REQ-037 SHALL cover: i_load_start with len=0 -> one o_load_err pulse, state and o_loaded unchanged; len=256 (the maximum at ADDR_WIDTH=8) -> accepted, counter ends at address 255.
REQ-038 SHALL cover: rst asserted after 2 of 4 beats -> all outputs at reset values next cycle; a following len=1 load completes normally.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared types and constants for the ROM load/read controller.
package rom_pkg;

  // Controller phases: waiting for a first load, streaming words in,
  // letting the final write commit, and serving reads.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    READY = 2'd3
  } rom_state_e;

  // Cycles from presenting an address on the controller's ROM port to the
  // read data being capturable; the same figure covers a write commit.
  localparam int ROM_LAT = 2;

endpackage

// File: rtl/rom.sv
// Downstream ROM model: registers its inputs, commits a write one edge later
// and presents read data for the registered address combinationally.
module rom #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  // Input register stage; reset drops any write that has not committed yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      we_q      <= we;
      addr_q    <= addr;
      wr_data_q <= wr_data;
    end
  end

  // Commit the registered write into the array one edge after it was registered.
  always_ff @(posedge clk) begin
    if (we_q) begin
      mem[addr_q] <= wr_data_q;
    end
  end

  assign rd_data = mem[addr_q];

endmodule

// File: rtl/rom_ctrl.sv
// ROM controller: loads a word stream into the ROM, then serves
// single-outstanding reads with a fixed two-cycle latency and bounds check.
module rom_ctrl
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH:0]   i_load_len,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_err,
  output logic                  o_rd_valid,
  input  logic                  i_rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rom_wr_data,
  output logic                  o_rom_we,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_rd_data,
  output logic                  o_load_done,
  output logic                  o_load_err,
  output logic                  o_loaded
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [1:0]          FLUSH_LAST = 2'(ROM_LAT - 1);
  localparam logic [1:0]          RD_LAST    = 2'(ROM_LAT - 1);

  rom_state_e          state;
  rom_state_e          state_nxt;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] cnt_q;
  logic [1:0]          flush_cnt;
  logic [1:0]          rd_cnt;
  logic                rd_pend;
  logic                rd_oob;

  logic start_seen;
  logic len_ok;
  logic start_ok;
  logic start_bad;
  logic beat;
  logic last_beat;
  logic rd_accept;
  logic rsp_done;
  logic flush_end;

  // Handshake and event decode; a read still in flight holds off load beats
  // so the ROM address port is not stolen before the read data is captured.
  always_comb begin
    start_seen = i_load_start && ((state == IDLE) || (state == READY));
    len_ok     = (i_load_len != '0) && (i_load_len <= MAX_LEN);
    start_ok   = start_seen && len_ok;
    start_bad  = start_seen && !len_ok;
    o_s_ready  = (state == LOAD) && !rd_pend;
    beat       = o_s_ready && i_s_valid;
    last_beat  = beat && (cnt_q == (len_q - ONE));
    o_rd_ready = (state == READY) && !rd_pend && !o_rd_valid;
    rd_accept  = o_rd_ready && i_rd_valid;
    rsp_done   = o_rd_valid && i_rd_rsp_ready;
    flush_end  = (state == FLUSH) && (flush_cnt == FLUSH_LAST);
  end

  // Next-state selection for the load/serve sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)  state_nxt = LOAD;
      LOAD:    if (last_beat) state_nxt = FLUSH;
      FLUSH:   if (flush_end) state_nxt = READY;
      READY:   if (start_ok)  state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load bookkeeping: latched length, word counter, flush timer and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      cnt_q       <= '0;
      flush_cnt   <= '0;
      o_loaded    <= 1'b0;
      o_load_done <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      o_load_done <= flush_end;
      o_load_err  <= start_bad;
      if (start_ok) begin
        len_q    <= i_load_len;
        cnt_q    <= '0;
        o_loaded <= 1'b0;
      end
      if (beat) begin
        cnt_q <= cnt_q + ONE;
      end
      if (last_beat) begin
        flush_cnt <= '0;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 2'd1;
      end
      if (flush_end) begin
        o_loaded <= 1'b1;
      end
    end
  end

  // ROM port drive plus the read pipeline and its held response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rom_we      <= 1'b0;
      o_rom_addr    <= '0;
      o_rom_wr_data <= '0;
      rd_pend       <= 1'b0;
      rd_cnt        <= '0;
      rd_oob        <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_data     <= '0;
      o_rd_err      <= 1'b0;
    end else begin
      o_rom_we <= beat;
      if (beat) begin
        o_rom_addr    <= cnt_q[ADDR_WIDTH-1:0];
        o_rom_wr_data <= i_s_data;
      end else if (rd_accept) begin
        o_rom_addr <= i_rd_addr;
        rd_pend    <= 1'b1;
        rd_cnt     <= '0;
        rd_oob     <= ({1'b0, i_rd_addr} >= len_q);
      end
      if (rd_pend) begin
        if (rd_cnt == RD_LAST) begin
          rd_pend    <= 1'b0;
          o_rd_valid <= 1'b1;
          o_rd_data  <= rd_oob ? '0 : i_rom_rd_data;
          o_rd_err   <= rd_oob;
        end else begin
          rd_cnt <= rd_cnt + 2'd1;
        end
      end else if (rsp_done) begin
        o_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_ctrl.sv
// Bench for rom_ctrl together with the rom model: table-driven reads,
// scoreboarded ROM writes and read responses, and hand-written load sequences.
module tb_rom_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_load_start;
  logic [AW:0]   i_load_len;
  logic [DW-1:0] i_s_data;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [AW-1:0] i_rd_addr;
  logic          i_rd_valid;
  logic          o_rd_ready;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_err;
  logic          o_rd_valid;
  logic          i_rd_rsp_ready;
  logic [DW-1:0] o_rom_wr_data;
  logic          o_rom_we;
  logic [AW-1:0] o_rom_addr;
  logic [DW-1:0] i_rom_rd_data;
  logic          o_load_done;
  logic          o_load_err;
  logic          o_loaded;

  rom_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_load_start   (i_load_start),
    .i_load_len     (i_load_len),
    .i_s_data       (i_s_data),
    .i_s_valid      (i_s_valid),
    .o_s_ready      (o_s_ready),
    .i_rd_addr      (i_rd_addr),
    .i_rd_valid     (i_rd_valid),
    .o_rd_ready     (o_rd_ready),
    .o_rd_data      (o_rd_data),
    .o_rd_err       (o_rd_err),
    .o_rd_valid     (o_rd_valid),
    .i_rd_rsp_ready (i_rd_rsp_ready),
    .o_rom_wr_data  (o_rom_wr_data),
    .o_rom_we       (o_rom_we),
    .o_rom_addr     (o_rom_addr),
    .i_rom_rd_data  (i_rom_rd_data),
    .o_load_done    (o_load_done),
    .o_load_err     (o_load_err),
    .o_loaded       (o_loaded)
  );

  rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_rom (
    .clk     (clk),
    .rst     (rst),
    .we      (o_rom_we),
    .addr    (o_rom_addr),
    .wr_data (o_rom_wr_data),
    .rd_data (i_rom_rd_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            stall;
  } rd_vec_t;

  typedef struct {
    int   len;
    logic exp_loaded;
    logic exp_rd_ready;
  } err_vec_t;

  wr_exp_t  wr_q[$];
  rd_exp_t  rd_q[$];
  rd_vec_t  rd_tab[6];
  rd_vec_t  rd_tab2[3];
  err_vec_t err_tab[3];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;
  logic rd_prev  = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_step();
    wr_exp_t w;
    rd_exp_t r;
    if (mon_en) begin
      if (o_rom_we) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_rom_we", 64'd1, 64'd0);
        end else begin
          w = wr_q.pop_front();
          checkOutput("rom_addr", 64'(o_rom_addr), 64'(w.addr));
          checkOutput("rom_wr_data", 64'(o_rom_wr_data), 64'(w.data));
          checkOutput("rom_we_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (o_rd_valid && !rd_prev) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_rd_valid", 64'd1, 64'd0);
        end else begin
          r = rd_q.pop_front();
          checkOutput("rd_data", 64'(o_rd_data), 64'(r.data));
          checkOutput("rd_err", 64'(o_rd_err), 64'(r.err));
          checkOutput("rd_latency", 64'(cyc - r.cyc), 64'd2);
        end
      end
    end
    rd_prev = o_rd_valid;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_s_ready"},    64'(o_s_ready),     64'd0);
    checkOutput({tag, "_rd_ready"},   64'(o_rd_ready),    64'd0);
    checkOutput({tag, "_rd_valid"},   64'(o_rd_valid),    64'd0);
    checkOutput({tag, "_rd_err"},     64'(o_rd_err),      64'd0);
    checkOutput({tag, "_rom_we"},     64'(o_rom_we),      64'd0);
    checkOutput({tag, "_load_done"},  64'(o_load_done),   64'd0);
    checkOutput({tag, "_load_err"},   64'(o_load_err),    64'd0);
    checkOutput({tag, "_loaded"},     64'(o_loaded),      64'd0);
    checkOutput({tag, "_rom_addr"},   64'(o_rom_addr),    64'd0);
    checkOutput({tag, "_rom_wdata"},  64'(o_rom_wr_data), 64'd0);
    checkOutput({tag, "_rd_data"},    64'(o_rd_data),     64'd0);
  endtask

  // Streams len words base+k with no stalls; abort_after >= 0 resets after that many beats.
  task automatic do_beats(input int len, input logic [DW-1:0] base, input int abort_after);
    int guard;
    for (int k = 0; k < len; k++) begin
      if (k == abort_after) begin
        i_s_valid = 1'b0;
        rst = 1'b1;
        step();
        check_reset_values("mid_load_reset");
        checkOutput("wr_q_drained_at_reset", 64'(wr_q.size()), 64'd0);
        wr_q.delete();
        rd_q.delete();
        rst = 1'b0;
        return;
      end
      guard = 0;
      while (!o_s_ready && guard < 20) begin
        i_s_valid = 1'b0;
        step();
        guard++;
      end
      if (!o_s_ready) begin
        checkOutput("s_ready_timeout", 64'd0, 64'd1);
        i_s_valid = 1'b0;
        return;
      end
      i_s_data  = base + DW'(k);
      i_s_valid = 1'b1;
      wr_q.push_back('{addr: AW'(k), data: base + DW'(k), cyc: cyc + 1});
      step();
    end
    i_s_valid = 1'b0;
    checkOutput("s_ready_after_last", 64'(o_s_ready), 64'd0);
    checkOutput("load_done_c1", 64'(o_load_done), 64'd0);
    step();
    checkOutput("load_done_c2", 64'(o_load_done), 64'd0);
    step();
    checkOutput("load_done_c3", 64'(o_load_done), 64'd1);
    checkOutput("loaded_set", 64'(o_loaded), 64'd1);
    checkOutput("rd_ready_in_ready", 64'(o_rd_ready), 64'd1);
    step();
    checkOutput("load_done_pulse_end", 64'(o_load_done), 64'd0);
  endtask

  task automatic run_load(input int len, input logic [DW-1:0] base, input int abort_after);
    i_load_start = 1'b1;
    i_load_len   = (AW+1)'(len);
    step();
    i_load_start = 1'b0;
    checkOutput("load_started_s_ready", 64'(o_s_ready), 64'd1);
    checkOutput("load_started_loaded", 64'(o_loaded), 64'd0);
    do_beats(len, base, abort_after);
  endtask

  task automatic load_err_check(input err_vec_t v);
    i_load_start = 1'b1;
    i_load_len   = (AW+1)'(v.len);
    step();
    i_load_start = 1'b0;
    checkOutput($sformatf("len%0d_load_err", v.len), 64'(o_load_err), 64'd1);
    checkOutput($sformatf("len%0d_loaded", v.len), 64'(o_loaded), 64'(v.exp_loaded));
    checkOutput($sformatf("len%0d_s_ready", v.len), 64'(o_s_ready), 64'd0);
    checkOutput($sformatf("len%0d_rd_ready", v.len), 64'(o_rd_ready), 64'(v.exp_rd_ready));
    step();
    checkOutput($sformatf("len%0d_err_pulse_end", v.len), 64'(o_load_err), 64'd0);
  endtask

  // One read: request, scoreboard push, optional response stall, handshake.
  task automatic applyStimulus(input rd_vec_t v);
    int guard;
    guard = 0;
    while (!o_rd_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!o_rd_ready) begin
      checkOutput("rd_ready_timeout", 64'd0, 64'd1);
      return;
    end
    i_rd_rsp_ready = 1'b0;
    i_rd_addr      = v.addr;
    i_rd_valid     = 1'b1;
    rd_q.push_back('{data: v.exp_data, err: v.exp_err, cyc: cyc + 1});
    step();
    i_rd_valid = 1'b0;
    guard = 0;
    while (!o_rd_valid && guard < 10) begin
      step();
      guard++;
    end
    if (!o_rd_valid) begin
      checkOutput("rd_valid_timeout", 64'd0, 64'd1);
      return;
    end
    for (int s = 0; s < v.stall; s++) begin
      checkOutput("stall_rd_ready", 64'(o_rd_ready), 64'd0);
      step();
      checkOutput("stall_rd_valid", 64'(o_rd_valid), 64'd1);
      checkOutput("stall_rd_data", 64'(o_rd_data), 64'(v.exp_data));
      checkOutput("stall_rd_err", 64'(o_rd_err), 64'(v.exp_err));
    end
    i_rd_rsp_ready = 1'b1;
    step();
    i_rd_rsp_ready = 1'b0;
    checkOutput("rd_valid_cleared", 64'(o_rd_valid), 64'd0);
    checkOutput("rd_ready_after_hs", 64'(o_rd_ready), 64'd1);
  endtask

  initial begin
    i_load_start   = 1'b0;
    i_load_len     = '0;
    i_s_data       = '0;
    i_s_valid      = 1'b0;
    i_rd_addr      = '0;
    i_rd_valid     = 1'b0;
    i_rd_rsp_ready = 1'b0;

    rd_tab[0] = '{addr: 8'd2,   exp_data: 32'hA2, exp_err: 1'b0, stall: 0};
    rd_tab[1] = '{addr: 8'd3,   exp_data: 32'hA3, exp_err: 1'b0, stall: 0};
    rd_tab[2] = '{addr: 8'd5,   exp_data: 32'h0,  exp_err: 1'b1, stall: 0};
    rd_tab[3] = '{addr: 8'd0,   exp_data: 32'hA0, exp_err: 1'b0, stall: 5};
    rd_tab[4] = '{addr: 8'd4,   exp_data: 32'h0,  exp_err: 1'b1, stall: 0};
    rd_tab[5] = '{addr: 8'd255, exp_data: 32'h0,  exp_err: 1'b1, stall: 2};

    rd_tab2[0] = '{addr: 8'd255, exp_data: 32'h10FF, exp_err: 1'b0, stall: 0};
    rd_tab2[1] = '{addr: 8'd0,   exp_data: 32'h1000, exp_err: 1'b0, stall: 0};
    rd_tab2[2] = '{addr: 8'd128, exp_data: 32'h1080, exp_err: 1'b0, stall: 1};

    err_tab[0] = '{len: 0,   exp_loaded: 1'b1, exp_rd_ready: 1'b1};
    err_tab[1] = '{len: 257, exp_loaded: 1'b1, exp_rd_ready: 1'b1};
    err_tab[2] = '{len: 511, exp_loaded: 1'b1, exp_rd_ready: 1'b1};

    rst = 1'b1;
    step();
    step();
    check_reset_values("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    $display("[TB] invalid length while idle");
    load_err_check('{len: 0, exp_loaded: 1'b0, exp_rd_ready: 1'b0});

    $display("[TB] load of four words");
    run_load(4, 32'hA0, -1);

    $display("[TB] read table after four-word load");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(rd_tab[i]);
    end

    $display("[TB] invalid lengths while ready");
    for (int i = 0; i < 3; i++) begin
      load_err_check(err_tab[i]);
    end

    $display("[TB] load start with a read in flight, full-depth load");
    while (!o_rd_ready) step();
    i_rd_addr      = 8'd3;
    i_rd_valid     = 1'b1;
    i_rd_rsp_ready = 1'b1;
    i_load_start   = 1'b1;
    i_load_len     = 9'd256;
    rd_q.push_back('{data: 32'hA3, err: 1'b0, cyc: cyc + 1});
    step();
    i_rd_valid   = 1'b0;
    i_load_start = 1'b0;
    checkOutput("inflight_s_ready_n", 64'(o_s_ready), 64'd0);
    checkOutput("inflight_loaded_cleared", 64'(o_loaded), 64'd0);
    step();
    checkOutput("inflight_s_ready_n1", 64'(o_s_ready), 64'd0);
    step();
    checkOutput("inflight_s_ready_n2", 64'(o_s_ready), 64'd1);
    do_beats(256, 32'h1000, -1);
    i_rd_rsp_ready = 1'b0;
    checkOutput("last_wr_addr", 64'(o_rom_addr), 64'd255);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rd_tab2[i]);
    end

    $display("[TB] reset in the middle of a load");
    run_load(4, 32'hB0, 2);
    step();
    checkOutput("post_reset_idle_s_ready", 64'(o_s_ready), 64'd0);
    checkOutput("post_reset_idle_rd_ready", 64'(o_rd_ready), 64'd0);

    $display("[TB] single-word load after reset");
    run_load(1, 32'hC5, -1);
    applyStimulus('{addr: 8'd0, exp_data: 32'hC5, exp_err: 1'b0, stall: 0});
    applyStimulus('{addr: 8'd1, exp_data: 32'h0,  exp_err: 1'b1, stall: 0});

    step();
    step();
    checkOutput("wr_q_empty_at_end", 64'(wr_q.size()), 64'd0);
    checkOutput("rd_q_empty_at_end", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
